// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier tile: accumulator FSM states,
// width limits, batch-length encoding and status-byte layout.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ACC_W_MAX = 12;

    // A 4-bit length field of zero stands for a full batch of 16 products.
    localparam logic [4:0] LEN_ZERO_IS_16 = 5'd16;

    localparam int STAT_DONE_BIT = 7;
    localparam int STAT_OVF_BIT  = 6;
    localparam int STAT_BUSY_BIT = 5;

    function automatic logic [4:0] decode_len(input logic [3:0] len);
        return (len == 4'd0) ? LEN_ZERO_IS_16 : {1'b0, len};
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a history flop that
// turns the synchronized level into a one-cycle rising-edge pulse.
module tt_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/prod_accumulator.sv
// Sums a programmable batch of 1..16 multiplier products into a saturating
// accumulator, driven by synchronized strobe/clear pins; byte-wide readout.
module prod_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       prod_i,
    input  logic             strobe_i,
    input  logic             clear_i,
    input  logic [3:0]       len_i,
    input  logic             sel_i,
    output logic [7:0]       byte_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             ovf_o
);

    if (ACC_W < 8 || ACC_W > ACC_W_MAX) begin : g_acc_w_check
        $error("prod_accumulator: ACC_W must lie in 8..12");
    end

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic accept;
    logic strobe_level_unused;
    logic clr;
    logic clr_rise_unused;

    // Strobe resets high so a pin already high at reset release is not an edge.
    tt_sync_edge #(.RST_VAL(1'b1)) u_strobe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (strobe_i),
        .level (strobe_level_unused),
        .rise  (accept)
    );

    tt_sync_edge #(.RST_VAL(1'b0)) u_clear_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (clear_i),
        .level (clr),
        .rise  (clr_rise_unused)
    );

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [4:0]       len_q,   len_d;
    logic             ovf_q,   ovf_d;

    logic [ACC_W:0]   sum;
    logic [4:0]       cnt_inc;

    assign sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_i);
    assign cnt_inc = cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_ZERO_IS_16;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every next-state value gets its hold default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(prod_i);
                        cnt_d   = 5'd1;
                        len_d   = decode_len(len_i);
                        state_d = (decode_len(len_i) == 5'd1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (sum[ACC_W]) begin
                            acc_d = ACC_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // Result is frozen until clear or reset.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign acc_o  = acc_q;
    assign ovf_o  = ovf_q;
    assign done_o = (state_q == DONE);
    assign busy_o = (state_q == ACCUM);

    logic [ACC_W_MAX-1:0] acc_ext;
    logic [7:0]           status;

    assign acc_ext = ACC_W_MAX'(acc_q);

    always_comb begin
        status                = '0;
        status[STAT_DONE_BIT] = done_o;
        status[STAT_OVF_BIT]  = ovf_q;
        status[STAT_BUSY_BIT] = busy_o;
        status[3:0]           = acc_ext[11:8];
    end

    assign byte_o = sel_i ? status : acc_q[7:0];

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench: a 12-bit and an 8-bit accumulator share stimulus and
// are compared against a batch-level reference model after every strobe.
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  prod;
    logic        strobe;
    logic        clear;
    logic [3:0]  len;
    logic        sel;

    logic [7:0]  byte12, byte8;
    logic [11:0] acc12;
    logic [7:0]  acc8;
    logic        done12, busy12, ovf12;
    logic        done8, busy8, ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .prod_i(prod), .strobe_i(strobe),
        .clear_i(clear), .len_i(len), .sel_i(sel), .byte_o(byte12),
        .acc_o(acc12), .done_o(done12), .busy_o(busy12), .ovf_o(ovf12)
    );

    prod_accumulator #(.ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .prod_i(prod), .strobe_i(strobe),
        .clear_i(clear), .len_i(len), .sel_i(sel), .byte_o(byte8),
        .acc_o(acc8), .done_o(done8), .busy_o(busy8), .ovf_o(ovf8)
    );

    // Reference model: raw (unclamped) running sum and count of the batch.
    int m_sum = 0;
    int m_cnt = 0;
    int m_len = 16;
    bit m_done = 1'b0;

    task automatic model_clear();
        m_sum  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic model_accept(input int p, input int l);
        if (m_done) return;
        if (m_cnt == 0) begin
            m_len = (l == 0) ? 16 : l;
            m_sum = p;
            m_cnt = 1;
        end else begin
            m_sum += p;
            m_cnt++;
        end
        if (m_cnt == m_len) m_done = 1'b1;
    endtask

    function automatic int exp_acc(input int w);
        int max_v = (1 << w) - 1;
        return (m_sum > max_v) ? max_v : m_sum;
    endfunction

    function automatic logic exp_ovf(input int w);
        return m_sum > ((1 << w) - 1);
    endfunction

    function automatic logic exp_busy();
        return (m_cnt > 0) && !m_done;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {12'(exp_acc(12)), m_done, exp_busy(), exp_ovf(12),
                8'(exp_acc(8)),   m_done, exp_busy(), exp_ovf(8)};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {acc12, done12, busy12, ovf12, acc8, done8, busy8, ovf8};
    endfunction

    function automatic logic [7:0] exp_byte(input int w, input logic s);
        logic [11:0] a = 12'(exp_acc(w));
        return s ? {m_done, exp_ovf(w), exp_busy(), 1'b0, a[11:8]} : a[7:0];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_prod(input logic [7:0] p);
        prod   = p;
        strobe = 1'b1;
        step(3);
        strobe = 1'b0;
        step(3);
        model_accept(p, len);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(3);
        clear = 1'b0;
        step(3);
        model_clear();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        strobe = 1'b1;
        clear  = 1'b0;
        sel    = 1'b0;
        prod   = 8'd0;
        len    = 4'd3;
        model_clear();
        step(3);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_outputs observed=%h expected=%h", obs_vec(), exp_vec());
        end
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({byte12, byte8} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_byte sel=%0d observed=%h expected=0000", s, {byte12, byte8});
            end
        end
        sel = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(10);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL strobe_high_through_reset observed=%h expected=%h", obs_vec(), exp_vec());
        end
        strobe = 1'b0;
        step(3);
    endtask

    task automatic test_batch3();
        logic [7:0] pl [3] = '{8'd15, 8'd225, 8'd1};
        pulse_clear();
        len = 4'd3;
        for (int i = 0; i < 3; i++) begin
            strobe_prod(pl[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL batch3_step%0d observed=%h expected=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({acc12, done12, busy12} !== {12'h0F1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL batch3_result observed=%h expected=%h", {acc12, done12, busy12}, {12'h0F1, 2'b10});
        end
        sel = 1'b0;
        #1;
        checks++;
        if ({byte12, byte8} !== 16'hF1F1) begin
            errors++;
            $display("FAIL batch3_byte_lo observed=%h expected=f1f1", {byte12, byte8});
        end
        sel = 1'b1;
        #1;
        checks++;
        if ({byte12, byte8} !== 16'h8080) begin
            errors++;
            $display("FAIL batch3_byte_hi observed=%h expected=8080", {byte12, byte8});
        end
        sel = 1'b0;
    endtask

    task automatic test_len16();
        pulse_clear();
        len = 4'd0;
        for (int i = 0; i < 15; i++) strobe_prod(8'd225);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL len16_after15 observed=%h expected=%h", obs_vec(), exp_vec());
        end
        strobe_prod(8'd225);
        checks++;
        if ({acc12, done12, busy12, ovf12} !== {12'd3600, 3'b100} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL len16_after16 observed=%h expected=%h", obs_vec(), exp_vec());
        end
        strobe_prod(8'd225);
        checks++;
        if (acc12 !== 12'd3600 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL len16_extra_strobe observed=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ovf8();
        pulse_clear();
        len = 4'd2;
        strobe_prod(8'd225);
        strobe_prod(8'd225);
        checks++;
        if ({acc8, ovf8} !== {8'd255, 1'b1} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf8_saturate observed=%h expected=%h", obs_vec(), exp_vec());
        end
        step(20);
        checks++;
        if (ovf8 !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf8_sticky observed=%h expected=%h", obs_vec(), exp_vec());
        end
        pulse_clear();
        checks++;
        if ({acc8, ovf8} !== 9'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf8_cleared observed=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_latency();
        logic [7:0] p;
        pulse_clear();
        len = 4'd3;
        p = 8'($urandom_range(1, 255));
        prod   = p;
        strobe = 1'b1;
        step(2);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL latency_before_n2 observed=%h expected=%h", obs_vec(), exp_vec());
        end
        step(1);
        model_accept(p, len);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL latency_at_n2 observed=%h expected=%h", obs_vec(), exp_vec());
        end
        step(47);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL long_high_single_accept observed=%h expected=%h", obs_vec(), exp_vec());
        end
        strobe = 1'b0;
        step(3);
        strobe_prod(8'($urandom_range(1, 255)));
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL next_rising_edge observed=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_collide();
        pulse_clear();
        len = 4'd4;
        strobe_prod(8'd10);
        prod   = 8'd50;
        strobe = 1'b1;
        clear  = 1'b1;
        step(3);
        strobe = 1'b0;
        clear  = 1'b0;
        step(3);
        model_clear();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clear_beats_accept observed=%h expected=%h", obs_vec(), exp_vec());
        end
        len = 4'd2;
        strobe_prod(8'd7);
        checks++;
        if ({acc12, busy12, done12} !== {12'd7, 2'b10} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_clear_first observed=%h expected=%h", obs_vec(), exp_vec());
        end
        strobe_prod(8'd8);
        checks++;
        if ({acc12, done12} !== {12'd15, 1'b1} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_clear_second observed=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        len = 4'd4;
        strobe_prod(8'd10);
        strobe_prod(8'd20);
        checks++;
        if ({acc12, busy12} !== {12'd30, 1'b1} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mid_batch_setup observed=%h expected=%h", obs_vec(), exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (obs_vec() !== 26'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_immediate observed=%h expected=%h", obs_vec(), exp_vec());
        end
        step(2);
        rst_n = 1'b1;
        step(3);
        len = 4'd1;
        strobe_prod(8'd6);
        checks++;
        if ({acc12, done12} !== {12'd6, 1'b1} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset_len1 observed=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int l;
            int n;
            pulse_clear();
            l   = $urandom_range(0, 6);
            len = 4'(l);
            n   = ((l == 0) ? 16 : l) + $urandom_range(0, 1);
            for (int i = 0; i < n; i++) begin
                strobe_prod(8'($urandom_range(0, 255)));
                len = 4'($urandom_range(0, 15));
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_b%0d_s%0d observed=%h expected=%h", b, i, obs_vec(), exp_vec());
                end
            end
            for (int s = 0; s < 2; s++) begin
                sel = s[0];
                #1;
                checks++;
                if ({byte12, byte8} !== {exp_byte(12, sel), exp_byte(8, sel)}) begin
                    errors++;
                    $display("FAIL random_b%0d_byte sel=%0d observed=%h expected=%h", b, s,
                             {byte12, byte8}, {exp_byte(12, sel), exp_byte(8, sel)});
                end
            end
            sel = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_batch3();
        test_len16();
        test_ovf8();
        test_latency();
        test_clear_collide();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
